inst_fetcher: RTL and testbench

- Front-end stage that sits directly upstream of the instruction decoder.
- Maintains the PC and issues one word fetch at a time to the icache.
- Buffers returned instructions with their PCs in a circular queue, which the decode/dispatch stage pops.
- Redirects on a ROB-issued jump/flush. Only one icache request is ever outstanding.

---
 rtl/inst_fetcher_pkg.sv | 12 +
 rtl/inst_queue.sv | 40 ++++
 rtl/inst_fetcher.sv | 75 +++++++
 tb/tb_inst_fetcher.sv | 134 +++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: opcodes, FSM states and queue entry layout shared by the fetch front-end.
package inst_fetcher_pkg;
  localparam logic [6:0] JAL_OPCODE = 7'b1101111;
  localparam logic [6:0] B_OPCODE = 7'b1100011;
  localparam int QUEUE_ENTRY_W = 65;
  typedef enum logic [1:0] {IDLE, WAIT_RESP, DROP} state_t;
  typedef struct packed {
    logic pred;
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular FIFO of fetched {pred, pc, inst}; full/empty come from count.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic   clk_in,
  input  logic   rstn_in,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  entry_t push_data,
  output entry_t head_data,
  output logic   not_empty,
  output logic   full
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  assign not_empty = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign head_data = not_empty ? mem[head] : '0;
  always_ff @(posedge clk_in or negedge rstn_in)
    if (!rstn_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk_in)
    if (push && !clear) mem[tail] <= push_data;
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: PC, single-outstanding icache fetch FSM and instruction queue.
// Optional static branch prediction on push: define INST_FETCHER_PREDICT_EN.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rstn_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  input  logic        ic_req_ready,
  output logic [31:0] ic_req_addr,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        queue_full
);
  state_t state, state_nx;
  logic [31:0] pc, next_pc;
  logic pred, push, pop;
  entry_t head;
  assign ic_req_valid = rstn_in && state == IDLE && rdy_in && !jump_en && !queue_full;
  assign ic_req_addr = pc;
  assign push = state == WAIT_RESP && ic_resp_valid && !jump_en;
  assign pop = out_valid && out_ready && rdy_in && !jump_en;
  assign out_inst = head.inst;
  assign out_pc = head.pc;
  assign out_pred_taken = head.pred;
`ifdef INST_FETCHER_PREDICT_EN
  logic [31:0] imm_j, imm_b;
  logic is_jal;
  assign imm_j = {{12{ic_resp_inst[31]}}, ic_resp_inst[19:12], ic_resp_inst[20], ic_resp_inst[30:21], 1'b0};
  assign imm_b = {{20{ic_resp_inst[31]}}, ic_resp_inst[7], ic_resp_inst[30:25], ic_resp_inst[11:8], 1'b0};
  assign is_jal = ic_resp_inst[6:0] == JAL_OPCODE;
  assign pred = is_jal || (ic_resp_inst[6:0] == B_OPCODE && ic_resp_inst[31]);
  assign next_pc = pc + (is_jal ? imm_j : pred ? imm_b : 32'd4);
`else
  assign pred = 1'b0;
  assign next_pc = pc + 32'd4;
`endif
  // A flush with the response already on the bus needs no DROP cycle.
  always_comb begin
    state_nx = state;
    if (jump_en) state_nx = state == WAIT_RESP ? (ic_resp_valid ? IDLE : DROP) : state;
    else if (state == IDLE) state_nx = (ic_req_valid && ic_req_ready) ? WAIT_RESP : IDLE;
    else state_nx = ic_resp_valid ? IDLE : state;
  end
  always_ff @(posedge clk_in or negedge rstn_in)
    if (!rstn_in) begin
      state <= IDLE;
      pc <= RESET_PC;
    end else begin
      state <= state_nx;
      pc <= jump_en ? jump_pc : push ? next_pc : pc;
    end
  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk_in(clk_in),
    .rstn_in(rstn_in),
    .push(push),
    .pop(pop),
    .clear(jump_en),
    .push_data('{pred: pred, pc: pc, inst: ic_resp_inst}),
    .head_data(head),
    .not_empty(out_valid),
    .full(queue_full)
  );
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: randomized stimulus with a queue-based fetch model and scoreboard monitor.
module tb_inst_fetcher;
  localparam int DEPTH = 8;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic pred;
  } ent_t;
  logic clk_in = 0, rstn_in = 0, rdy_in = 0, ic_req_valid, ic_req_ready = 0;
  logic [31:0] ic_req_addr, ic_resp_inst = 0, out_inst, out_pc, jump_pc = 0;
  logic ic_resp_valid = 0, out_valid, out_ready = 0, out_pred_taken, jump_en = 0, queue_full;
  int checks = 0, errors = 0;
  always #5 clk_in = ~clk_in;
  inst_fetcher dut (
    .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_pred_taken(out_pred_taken), .jump_en(jump_en), .jump_pc(jump_pc), .queue_full(queue_full)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  // Returns {taken, next fetch address} for a word fetched at pc.
  function automatic logic [32:0] predict(input logic [31:0] pc, input logic [31:0] i);
`ifdef INST_FETCHER_PREDICT_EN
    logic [31:0] jo, bo;
    jo = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    bo = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    if (i[6:0] == 7'b1101111) return {1'b1, pc + jo};
    if (i[6:0] == 7'b1100011 && i[31]) return {1'b1, pc + bo};
`endif
    return {1'b0, pc + 32'd4};
  endfunction
  function automatic logic [31:0] pick_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return 32'h00000013;
      1: return 32'h0080006F;
      2: begin r[6:0] = 7'b1100011; r[31] = 1'b1; return r; end
      3: begin r[6:0] = 7'b1100011; r[31] = 1'b0; return r; end
      default: return r;
    endcase
  endfunction
  // Scoreboard: expected queue contents and fetch-stream state.
  ent_t q[$];
  logic [31:0] model_pc = 32'h0;
  bit inflight = 0, stale = 0, saw_full = 0;
  logic [32:0] pn;
  initial begin
    wait (rstn_in);
    forever begin
      @(negedge clk_in);
      #2;
      chk("out_valid", out_valid, q.size() != 0);
      chk("queue_full", queue_full, q.size() == DEPTH);
      if (q.size() != 0) begin
        chk("out_inst", out_inst, q[0].inst);
        chk("out_pc", out_pc, q[0].pc);
        chk("out_pred_taken", out_pred_taken, q[0].pred);
      end
      chk("ic_req_valid", ic_req_valid, !inflight && rdy_in && !jump_en && q.size() < DEPTH);
      if (ic_req_valid) chk("ic_req_addr", ic_req_addr, model_pc);
      if (q.size() == DEPTH) saw_full = 1;
      if (jump_en) begin
        q.delete();
        model_pc = jump_pc;
        if (inflight && ic_resp_valid) inflight = 0;
        else if (inflight) stale = 1;
      end else begin
        if (q.size() != 0 && out_ready && rdy_in) void'(q.pop_front());
        if (inflight && ic_resp_valid) begin
          inflight = 0;
          if (!stale) begin
            pn = predict(model_pc, ic_resp_inst);
            q.push_back('{inst: ic_resp_inst, pc: model_pc, pred: pn[32]});
            model_pc = pn[31:0];
          end
          stale = 0;
        end else if (!inflight && rdy_in && q.size() < DEPTH && ic_req_ready) inflight = 1;
      end
    end
  end
  // Driver plus icache responder: one outstanding request answered after 1..3 cycles.
  initial begin
    bit pend = 0, flushed = 0, fill;
    int cd = 0;
    logic [31:0] r;
    repeat (3) @(negedge clk_in);
    #2;
    chk("rst_req_valid", ic_req_valid, 0);
    chk("rst_req_addr", ic_req_addr, 32'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_queue_full", queue_full, 0);
    @(negedge clk_in);
    rstn_in = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk_in);
      fill = c < 80;
      ic_resp_valid = 0;
      if (pend) begin
        if (cd <= 1) begin
          ic_resp_valid = 1;
          ic_resp_inst = fill ? 32'h00000013 : pick_inst();
          pend = 0;
        end else cd--;
      end
      rdy_in = fill ? 1'b1 : $urandom_range(0, 7) != 0;
      out_ready = fill ? 1'b0 : $urandom_range(0, 1) == 1;
      ic_req_ready = fill ? 1'b1 : $urandom_range(0, 3) != 0;
      jump_en = !fill && $urandom_range(0, 19) == 0 && !(ic_resp_valid && flushed);
      r = $urandom;
      jump_pc = {r[31:2], 2'b00};
      if (ic_resp_valid) flushed = 0;
      else if (jump_en && pend) flushed = 1;
      #1;
      if (ic_req_valid && ic_req_ready) begin
        pend = 1;
        cd = fill ? 2 : $urandom_range(1, 3);
      end
      if (c == 79) chk("fill_saw_full", saw_full, 1);
    end
    @(negedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
